// File: rtl/eq_sweep_amisha_pkg.sv
// Shared types and sizing helpers for the equality-comparator sweep block.
// DEF_* constants describe the default WIDTH=2 build; the functions size any WIDTH.
package eq_sweep_pkg_amisha;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 2;
  localparam int VEC_BITS  = 2 * DEF_WIDTH;
  localparam int NUM_VEC   = 1 << VEC_BITS;
  localparam int CNT_BITS  = VEC_BITS + 1;

  function automatic int vec_bits(input int width);
    return 2 * width;
  endfunction

  // One extra bit so the count can reach 2^(2*WIDTH) without wrapping.
  function automatic int cnt_bits(input int width);
    return 2 * width + 1;
  endfunction

endpackage

// File: rtl/eq_sweep_amisha_golden.sv
// Combinational WIDTH-bit equality reference used as the expected comparator result.
module eq_golden_amisha #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             eq_o
);

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/eq_sweep_amisha.sv
// Exhaustive (a,b) sweep of an external equality comparator; counts mismatches, keeps the first.
// Optional EQ_SWEEP_STOP_ON_FAIL_EN: end the sweep on the first mismatching sample.
module eq_sweep_amisha
  import eq_sweep_pkg_amisha::*;
#(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic               clk_amisha,
  input  logic               reset_amisha,
  input  logic               start_amisha,
  input  logic               eq_in_amisha,
  output logic [WIDTH-1:0]   a_amisha,
  output logic [WIDTH-1:0]   b_amisha,
  output logic               busy_amisha,
  output logic               done_amisha,
  output logic               pass_amisha,
  output logic [2*WIDTH:0]   err_cnt_amisha,
  output logic               fail_seen_amisha,
  output logic [WIDTH-1:0]   fail_a_amisha,
  output logic [WIDTH-1:0]   fail_b_amisha
);

  localparam int VB = vec_bits(WIDTH);
  localparam int CB = cnt_bits(WIDTH);
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE);

  state_e            state_q, state_d;
  logic [VB-1:0]     v_q, v_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [CB-1:0]     err_q, err_d;
  logic              fail_seen_q, fail_seen_d;
  logic [WIDTH-1:0]  fail_a_q, fail_a_d;
  logic [WIDTH-1:0]  fail_b_q, fail_b_d;
  logic              gold_eq, mism, last_vec, stop_now;

  eq_golden_amisha #(.WIDTH(WIDTH)) u_golden (
    .a_i  (v_q[VB-1:WIDTH]),
    .b_i  (v_q[WIDTH-1:0]),
    .eq_o (gold_eq)
  );

  assign mism     = eq_in_amisha ^ gold_eq;
  assign last_vec = &v_q;

`ifdef EQ_SWEEP_STOP_ON_FAIL_EN
  assign stop_now = mism;
`else
  assign stop_now = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    settle_d    = settle_q;
    err_d       = err_q;
    fail_seen_d = fail_seen_q;
    fail_a_d    = fail_a_q;
    fail_b_d    = fail_b_q;
    case (state_q)
      // DONE restarts exactly like IDLE, wiping the previous result on the same edge.
      IDLE, DONE: begin
        if (start_amisha) begin
          state_d     = RUN;
          v_d         = '0;
          settle_d    = SETTLE_LD;
          err_d       = '0;
          fail_seen_d = 1'b0;
          fail_a_d    = '0;
          fail_b_d    = '0;
        end
      end
      RUN: begin
        if (settle_q != '0) begin
          settle_d = settle_q - 1'b1;
        end else begin
          if (mism) begin
            err_d = err_q + 1'b1;
            if (!fail_seen_q) begin
              fail_seen_d = 1'b1;
              fail_a_d    = v_q[VB-1:WIDTH];
              fail_b_d    = v_q[WIDTH-1:0];
            end
          end
          if (last_vec || stop_now) begin
            state_d = DONE;
          end else begin
            v_d      = v_q + 1'b1;
            settle_d = SETTLE_LD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state_q     <= IDLE;
      v_q         <= '0;
      settle_q    <= '0;
      err_q       <= '0;
      fail_seen_q <= 1'b0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      settle_q    <= settle_d;
      err_q       <= err_d;
      fail_seen_q <= fail_seen_d;
      fail_a_q    <= fail_a_d;
      fail_b_q    <= fail_b_d;
    end
  end

  assign a_amisha         = v_q[VB-1:WIDTH];
  assign b_amisha         = v_q[WIDTH-1:0];
  assign busy_amisha      = (state_q == RUN);
  assign done_amisha      = (state_q == DONE);
  assign pass_amisha      = (state_q == DONE) && (err_q == '0);
  assign err_cnt_amisha   = err_q;
  assign fail_seen_amisha = fail_seen_q;
  assign fail_a_amisha    = fail_a_q;
  assign fail_b_amisha    = fail_b_q;

endmodule

// File: tb/tb_eq_sweep_amisha.sv
// Self-checking bench: emulated comparator (correct, stuck, random faults) vs. a counting reference.
module tb_eq_sweep_amisha;

  localparam int W  = 2;
  localparam int S  = 1;
  localparam int NV = 1 << (2 * W);

  logic           clk = 1'b0;
  logic           reset, start, eq_in;
  logic [W-1:0]   a, b, fa, fb;
  logic           busy, done, pass, fs;
  logic [2*W:0]   err;

  int n_chk  = 0;
  int n_pass = 0;
  int mode   = 0;
  bit fmap [NV];

  always #5 clk = ~clk;

  eq_sweep_amisha #(.WIDTH(W), .SETTLE(S)) dut (
    .clk_amisha       (clk),
    .reset_amisha     (reset),
    .start_amisha     (start),
    .eq_in_amisha     (eq_in),
    .a_amisha         (a),
    .b_amisha         (b),
    .busy_amisha      (busy),
    .done_amisha      (done),
    .pass_amisha      (pass),
    .err_cnt_amisha   (err),
    .fail_seen_amisha (fs),
    .fail_a_amisha    (fa),
    .fail_b_amisha    (fb)
  );

  // Comparator under test: 0 correct, 1 stuck-0, 2 stuck-1, 3 correct with injected inversions.
  always_comb begin
    eq_in = 1'b0;
    case (mode)
      0:       eq_in = (a == b);
      1:       eq_in = 1'b0;
      2:       eq_in = 1'b1;
      default: eq_in = (a == b) ^ fmap[{a, b}];
    endcase
  end

  function automatic bit ideal_eq(input int v);
    return (v / (1 << W)) == (v % (1 << W));
  endfunction

  function automatic bit cmp_out(input int v);
    case (mode)
      0:       return ideal_eq(v);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return ideal_eq(v) ^ fmap[v];
    endcase
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic run_sweep(input int inject_at, input int abort_at);
    int exp_err, ff, exp_total, last_v, k;
    exp_err = 0;
    ff      = -1;
    for (int v = 0; v < NV; v++) begin
      if (cmp_out(v) != ideal_eq(v)) begin
        exp_err++;
        if (ff < 0) ff = v;
      end
    end
    last_v    = NV - 1;
    exp_total = NV * (S + 1);
`ifdef EQ_SWEEP_STOP_ON_FAIL_EN
    if (ff >= 0) begin
      exp_err   = 1;
      last_v    = ff;
      exp_total = (ff + 1) * (S + 1);
    end
`endif
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 0;
    while (!done && k < exp_total + 20) begin
      if (k == abort_at) begin
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ab", {a, b}, 0);
        chk("abort_err", err, 0);
        chk("abort_fail_seen", fs, 0);
        return;
      end
      chk("run_busy", busy, 1);
      chk("run_vec", {a, b}, k / (S + 1));
      start = (k == inject_at);
      @(negedge clk) start = 1'b0;
      k++;
    end
    chk("latency", k, exp_total);
    chk("done", done, 1);
    chk("busy_end", busy, 0);
    chk("pass", pass, exp_err == 0);
    chk("err_cnt", err, exp_err);
    chk("fail_seen", fs, ff >= 0);
    if (ff >= 0) begin
      chk("fail_a", fa, ff / (1 << W));
      chk("fail_b", fb, ff % (1 << W));
    end
    chk("final_vec", {a, b}, last_v);
    repeat (3) @(negedge clk);
    chk("done_held", done, 1);
    chk("err_held", err, exp_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_ab", {a, b}, 0);
    chk("rst_err", err, 0);
    chk("rst_fail", {fs, fa, fb}, 0);

    mode = 0; run_sweep(-1, -1);
    mode = 1; run_sweep(-1, -1);
    mode = 2; run_sweep(-1, -1);
    mode = 0; run_sweep(5, -1);
    mode = 1; run_sweep(-1, 10);
    mode = 0; run_sweep(-1, -1);

    // Reset and start together: reset must win.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("rst_vs_start_busy", busy, 0);
    chk("rst_vs_start_done", done, 0);
    @(negedge clk);
    chk("rst_vs_start_idle", busy, 0);

    for (int r = 0; r < 4; r++) begin
      mode = 3;
      for (int v = 0; v < NV; v++) fmap[v] = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_sweep(-1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
